// File: rtl/frame_mem_write_ctrl_pkg.sv
// frame_wr_pkg: shared types and constants for the frame memory write controller.
// Holds the controller state encoding, default parameter values and the
// counter width helper used for the bit-position and tail counters.
package frame_wr_pkg;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_TAIL = 1'b1
    } wr_state_e;

    localparam int DEF_DW        = 20;
    localparam int DEF_FW        = 24;
    localparam int DEF_NLINE     = 20;
    localparam int DEF_AW        = 5;
    localparam int DEF_TAIL      = 3;
    localparam int DEF_MSB_FIRST = 1;

    // Bits needed to count 0..n-1; never less than one bit.
    function automatic int cnt_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/frame_mem_write_ctrl_ser2par_shift.sv
// ser2par_shift: serial-in word assembler for the frame write controller.
// Shifts iMOSI in on every strobe that falls inside the data part of a frame.
// oWORD already includes the bit sampled in the current cycle, so the
// controller can register a finished word on the same edge that captures its
// last bit.
module ser2par_shift #(
    parameter int DW        = 20,
    parameter int MSB_FIRST = 1
) (
    input  logic          iCLK,
    input  logic          iRSTn,
    input  logic          iCLR,
    input  logic          iEN,
    input  logic          iMOSI,
    input  logic          iCAP,
    output logic [DW-1:0] oWORD
);

    logic [DW-1:0] shift_q;
    logic [DW-1:0] shift_d;
    logic [DW-1:0] shifted;

    generate
        if (DW == 1) begin : g_single
            assign shifted = iMOSI;
        end else if (MSB_FIRST != 0) begin : g_msb
            // First bit of the frame migrates up to the top bit.
            assign shifted = {shift_q[DW-2:0], iMOSI};
        end else begin : g_lsb
            // First bit of the frame migrates down to bit 0.
            assign shifted = {iMOSI, shift_q[DW-1:1]};
        end
    endgenerate

    // Next shift contents: advance only on strobes inside the data field.
    always_comb begin
        shift_d = shift_q;
        if (iEN && iCAP) begin
            shift_d = shifted;
        end
    end

    assign oWORD = shift_d;

    // Shift register storage.
    always_ff @(posedge iCLK or negedge iRSTn) begin
        if (!iRSTn) begin
            shift_q <= '0;
        end else if (iCLR) begin
            shift_q <= '0;
        end else begin
            shift_q <= shift_d;
        end
    end

endmodule

// File: rtl/frame_mem_write_ctrl.sv
// frame_mem_write_ctrl: SPI bitstream to line-memory write controller.
// Counts enabled bit strobes into FW-bit frames, writes the leading DW bits
// of each frame as one word to the next line address, and pulses oWr_DONE a
// fixed TAIL cycles after the last line of an image is written.
// Optional build macro FRAME_WR_PINGPONG_EN enables two-bank ping-pong with
// consumer release (iREL) and a sticky overflow flag (oOVF).
module frame_mem_write_ctrl
    import frame_wr_pkg::*;
#(
    parameter int DW        = DEF_DW,
    parameter int FW        = DEF_FW,
    parameter int NLINE     = DEF_NLINE,
    parameter int AW        = DEF_AW,
    parameter int TAIL      = DEF_TAIL,
    parameter int MSB_FIRST = DEF_MSB_FIRST
) (
    input  logic          iCLK,
    input  logic          iRSTn,
    input  logic          iCLR,
    input  logic          iEN,
    input  logic          iMOSI,
    input  logic [1:0]    iREL,
    output logic [DW-1:0] oDATA,
    output logic          oWr_EN,
    output logic [AW-1:0] oWr_ADDR,
    output logic          oWr_BANK,
    output logic          oWr_DONE,
    output logic          oOVF
);

    localparam int BW = cnt_w(FW);
    localparam int TW = cnt_w(TAIL);
    localparam logic [BW-1:0] BIT_LAST  = BW'(FW - 1);
    localparam logic [BW-1:0] BIT_WORD  = BW'(DW - 1);
    localparam logic [AW-1:0] LINE_LAST = AW'(NLINE - 1);
    localparam logic [TW-1:0] TAIL_LAST = TW'(TAIL - 1);

    logic [BW-1:0] bit_cnt_q;
    logic [BW-1:0] bit_cnt_d;
    logic          capture;
    logic          word_done;
    logic          bank_full;
    logic          last_wr;
    logic [DW-1:0] word;

    wr_state_e     state_q;
    logic [TW-1:0] tail_cnt_q;
    logic [AW-1:0] line_cnt_q;
    logic [DW-1:0] data_q;
    logic          wr_en_q;
    logic [AW-1:0] addr_q;
    logic          done_q;

    // Data bits occupy the first DW strobes of the frame; the rest is padding.
    assign capture   = (bit_cnt_q <= BIT_WORD);
    assign word_done = iEN && (bit_cnt_q == BIT_WORD);
    assign last_wr   = word_done && !bank_full && (line_cnt_q == LINE_LAST);

    ser2par_shift #(
        .DW        (DW),
        .MSB_FIRST (MSB_FIRST)
    ) u_shift (
        .iCLK  (iCLK),
        .iRSTn (iRSTn),
        .iCLR  (iCLR),
        .iEN   (iEN),
        .iMOSI (iMOSI),
        .iCAP  (capture),
        .oWORD (word)
    );

    // Bit position within the frame, wrapping at FW-1.
    always_comb begin
        bit_cnt_d = bit_cnt_q;
        if (iEN) begin
            bit_cnt_d = (bit_cnt_q == BIT_LAST) ? '0 : bit_cnt_q + BW'(1);
        end
    end

    // Bit position register.
    always_ff @(posedge iCLK or negedge iRSTn) begin
        if (!iRSTn) begin
            bit_cnt_q <= '0;
        end else if (iCLR) begin
            bit_cnt_q <= '0;
        end else begin
            bit_cnt_q <= bit_cnt_d;
        end
    end

    // Write sequencing: registered write strobe/data/address, line counter,
    // and the RUN/TAIL state machine that times the completion pulse.
    always_ff @(posedge iCLK or negedge iRSTn) begin
        if (!iRSTn) begin
            state_q    <= ST_RUN;
            tail_cnt_q <= '0;
            line_cnt_q <= '0;
            data_q     <= '0;
            wr_en_q    <= 1'b0;
            addr_q     <= '0;
            done_q     <= 1'b0;
        end else if (iCLR) begin
            state_q    <= ST_RUN;
            tail_cnt_q <= '0;
            line_cnt_q <= '0;
            data_q     <= '0;
            wr_en_q    <= 1'b0;
            addr_q     <= '0;
            done_q     <= 1'b0;
        end else begin
            wr_en_q <= 1'b0;
            done_q  <= 1'b0;
            if (word_done && !bank_full) begin
                wr_en_q <= 1'b1;
                data_q  <= word;
                addr_q  <= line_cnt_q;
                if (line_cnt_q == LINE_LAST) begin
                    line_cnt_q <= '0;
                    state_q    <= ST_TAIL;
                    tail_cnt_q <= '0;
                end else begin
                    line_cnt_q <= line_cnt_q + AW'(1);
                end
            end
            // Tail timing keeps running while the next image is captured.
            if (state_q == ST_TAIL) begin
                if (tail_cnt_q == TAIL_LAST) begin
                    done_q     <= 1'b1;
                    state_q    <= ST_RUN;
                    tail_cnt_q <= '0;
                end else begin
                    tail_cnt_q <= tail_cnt_q + TW'(1);
                end
            end
        end
    end

    assign oDATA    = data_q;
    assign oWr_EN   = wr_en_q;
    assign oWr_ADDR = addr_q;
    assign oWr_DONE = done_q;

`ifdef FRAME_WR_PINGPONG_EN
    logic [1:0] full_q;
    logic [1:0] set_full;
    logic       bank_q;
    logic       wr_bank_q;
    logic       ovf_q;

    assign bank_full = full_q[bank_q];

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_set_full
            assign set_full[gi] = last_wr && (bank_q == 1'(gi));
        end
    endgenerate

    // Full flags: set when a bank's image completes, cleared by the
    // consumer's release; a simultaneous set overrides the release.
    always_ff @(posedge iCLK or negedge iRSTn) begin
        if (!iRSTn) begin
            full_q <= '0;
        end else if (iCLR) begin
            full_q <= '0;
        end else begin
            full_q <= (full_q & ~iREL) | set_full;
        end
    end

    // Fill bank selection, per-write bank echo and sticky overflow.
    always_ff @(posedge iCLK or negedge iRSTn) begin
        if (!iRSTn) begin
            bank_q    <= 1'b0;
            wr_bank_q <= 1'b0;
            ovf_q     <= 1'b0;
        end else if (iCLR) begin
            bank_q    <= 1'b0;
            wr_bank_q <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            if (word_done && bank_full) begin
                ovf_q <= 1'b1;
            end
            if (word_done && !bank_full) begin
                wr_bank_q <= bank_q;
            end
            if (last_wr) begin
                bank_q <= ~bank_q;
            end
        end
    end

    assign oWr_BANK = wr_bank_q;
    assign oOVF     = ovf_q;
`else
    // Single-bank build: images always overwrite bank 0, release is ignored.
    logic unused_rel;
    assign unused_rel = ^iREL;
    assign bank_full  = 1'b0;
    assign oWr_BANK   = 1'b0;
    assign oOVF       = 1'b0;
`endif

endmodule

// File: tb/tb_frame_mem_write_ctrl.sv
// Directed self-checking bench for frame_mem_write_ctrl.
// Drives one bitstream into an MSB-first and an LSB-first instance and checks
// write timing, data, addresses, completion pulse and bank behaviour.
module tb_frame_mem_write_ctrl;

    localparam int DW    = 20;
    localparam int FW    = 24;
    localparam int NLINE = 20;
    localparam int AW    = 5;
    localparam int TAIL  = 3;
`ifdef FRAME_WR_PINGPONG_EN
    localparam logic PP = 1'b1;
`else
    localparam logic PP = 1'b0;
`endif

    typedef struct packed {
        int            stamp;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [DW-1:0] ldata;
        logic          bank;
    } wr_rec_t;

    logic          clk = 1'b0;
    logic          iRSTn;
    logic          iCLR;
    logic          iEN;
    logic          iMOSI;
    logic [1:0]    iREL;
    logic [DW-1:0] oDATA;
    logic          oWr_EN;
    logic [AW-1:0] oWr_ADDR;
    logic          oWr_BANK;
    logic          oWr_DONE;
    logic          oOVF;
    logic [DW-1:0] l_data;
    logic          unused_l_en;
    logic [AW-1:0] unused_l_addr;
    logic          unused_l_bank;
    logic          unused_l_done;
    logic          unused_l_ovf;

    int      pcnt = 0;
    int      n_checks = 0;
    int      n_fail = 0;
    int      done_cnt = 0;
    int      last_done = 0;
    int      first_edge = 0;
    int      word_edge = 0;
    wr_rec_t wr_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) pcnt <= pcnt + 1;

    frame_mem_write_ctrl #(.DW(DW), .FW(FW), .NLINE(NLINE), .AW(AW), .TAIL(TAIL), .MSB_FIRST(1)) dut (
        .iCLK(clk), .iRSTn(iRSTn), .iCLR(iCLR), .iEN(iEN), .iMOSI(iMOSI), .iREL(iREL),
        .oDATA(oDATA), .oWr_EN(oWr_EN), .oWr_ADDR(oWr_ADDR), .oWr_BANK(oWr_BANK),
        .oWr_DONE(oWr_DONE), .oOVF(oOVF)
    );

    frame_mem_write_ctrl #(.DW(DW), .FW(FW), .NLINE(NLINE), .AW(AW), .TAIL(TAIL), .MSB_FIRST(0)) dut_lsb (
        .iCLK(clk), .iRSTn(iRSTn), .iCLR(iCLR), .iEN(iEN), .iMOSI(iMOSI), .iREL(iREL),
        .oDATA(l_data), .oWr_EN(unused_l_en), .oWr_ADDR(unused_l_addr), .oWr_BANK(unused_l_bank),
        .oWr_DONE(unused_l_done), .oOVF(unused_l_ovf)
    );

    // Record every write and completion pulse, stamped with the edge that produced it.
    always @(negedge clk) begin
        wr_rec_t r;
        if (oWr_EN) begin
            r.stamp = pcnt;
            r.addr  = oWr_ADDR;
            r.data  = oDATA;
            r.ldata = l_data;
            r.bank  = oWr_BANK;
            wr_q.push_back(r);
            $display("WR   edge=%0d addr=%0d data=%05h lsb=%05h bank=%0d", pcnt, oWr_ADDR, oDATA, l_data, oWr_BANK);
        end
        if (oWr_DONE) begin
            done_cnt++;
            last_done = pcnt;
            $display("DONE edge=%0d", pcnt);
        end
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] pat(input int k);
        if (k == 1) return 20'h80000;
        return DW'(32'h3C000 + 32'(k) * 32'h1111);
    endfunction

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Send one frame MSB-first; padding bits are driven as 1 to show they are ignored.
    // clr_at >= 0 asserts iCLR together with that bit and abandons the frame.
    task automatic send_frame(input logic [DW-1:0] w, input int gap, input int clr_at);
        for (int i = 0; i < FW; i++) begin
            iEN = 1'b1;
            if (i < DW) iMOSI = w[DW-1-i];
            else        iMOSI = 1'b1;
            iCLR = (i == clr_at);
            @(posedge clk);
            #1;
            if (i == 0) first_edge = pcnt;
            if (i == DW - 1) word_edge = pcnt;
            if (i == clr_at) begin
                iCLR = 1'b0;
                iEN  = 1'b0;
                return;
            end
            for (int g = 0; g < gap; g++) begin
                iEN = 1'b0;
                @(posedge clk);
                #1;
            end
        end
        iEN = 1'b0;
    endtask

    task automatic expect_wr(input string tag, input int a, input logic [DW-1:0] d, input logic b,
                             output wr_rec_t r);
        r = '0;
        check_val({tag, ".count"}, 32'(wr_q.size()), 32'd1);
        if (wr_q.size() > 0) begin
            r = wr_q.pop_front();
            check_val({tag, ".latency"}, 32'(r.stamp), 32'(word_edge));
            check_val({tag, ".addr"}, 32'(r.addr), 32'(a));
            check_val({tag, ".data"}, 32'(r.data), 32'(d));
            check_val({tag, ".bank"}, 32'(r.bank), 32'(b));
        end
        wr_q.delete();
    endtask

    task automatic pulse_clr();
        iCLR = 1'b1;
        idle(1);
        iCLR = 1'b0;
    endtask

    initial begin
        wr_rec_t   r;
        int        e19;
        logic [DW-1:0] gdat [3];
        gdat[0] = 20'hA5A5F;
        gdat[1] = 20'h12345;
        gdat[2] = 20'hFEDCB;

        iRSTn = 1'b0; iCLR = 1'b0; iEN = 1'b0; iMOSI = 1'b0; iREL = 2'b00;
        idle(3);
        iRSTn = 1'b1;
        idle(1);
        check_val("rst.wr_en", 32'(oWr_EN), 32'd0);
        check_val("rst.data", 32'(oDATA), 32'd0);
        check_val("rst.addr", 32'(oWr_ADDR), 32'd0);
        check_val("rst.bank", 32'(oWr_BANK), 32'd0);
        check_val("rst.done", 32'(oWr_DONE), 32'd0);
        check_val("rst.ovf", 32'(oOVF), 32'd0);

        // First frame, continuous strobes.
        send_frame(20'hA5A5F, 0, -1);
        check_val("f0.first_to_word", 32'(word_edge - first_edge), 32'd19);
        expect_wr("f0", 0, 20'hA5A5F, 1'b0, r);
        check_val("f0.lsb_data", 32'(r.ldata), 32'hFA5A5);

        // Rest of the image back-to-back, then completion timing.
        e19 = 0;
        for (int k = 1; k < NLINE; k++) begin
            send_frame(pat(k), 0, -1);
            expect_wr($sformatf("img.w%0d", k), k, pat(k), 1'b0, r);
            if (k == 1) check_val("lsb.first_bit", 32'(r.ldata), 32'h00001);
            if (k == NLINE - 1) e19 = word_edge;
        end
        check_val("img.done_count", 32'(done_cnt), 32'd1);
        check_val("img.done_delay", 32'(last_done - e19), 32'(TAIL));
        send_frame(pat(20), 0, -1);
        expect_wr("img.wrap", 0, pat(20), PP, r);
        idle(10);
        check_val("img.no_extra_done", 32'(done_cnt), 32'd1);

        // Clear in the middle of a frame.
        pulse_clr();
        check_val("clr.data", 32'(oDATA), 32'd0);
        for (int k = 0; k < 4; k++) begin
            send_frame(pat(30 + k), 0, -1);
            expect_wr($sformatf("clr.w%0d", k), k, pat(30 + k), 1'b0, r);
        end
        send_frame(20'h13579, 0, 10);
        idle(30);
        check_val("clr.abort_nowr", 32'(wr_q.size()), 32'd0);
        check_val("clr.addr", 32'(oWr_ADDR), 32'd0);
        check_val("clr.data2", 32'(oDATA), 32'd0);
        send_frame(20'h2468A, 0, -1);
        expect_wr("clr.resync", 0, 20'h2468A, 1'b0, r);

        // Gapped strobes: one every three cycles.
        pulse_clr();
        for (int j = 0; j < 3; j++) begin
            send_frame(gdat[j], 2, -1);
            check_val($sformatf("gap.w%0d.span", j), 32'(word_edge - first_edge), 32'd57);
            expect_wr($sformatf("gap.w%0d", j), j, gdat[j], 1'b0, r);
            if (j == 0) check_val("gap.lsb_data", 32'(r.ldata), 32'hFA5A5);
        end

        // Two full images, then a third image's first word.
        pulse_clr();
        done_cnt = 0;
        for (int k = 0; k < 2 * NLINE; k++) begin
            send_frame(pat(k), 0, -1);
            expect_wr($sformatf("bank.w%0d", k), k % NLINE, pat(k), PP & (k >= NLINE), r);
        end
        idle(4);
        check_val("bank.done_count", 32'(done_cnt), 32'd2);
        check_val("bank.ovf_before", 32'(oOVF), 32'd0);
`ifdef FRAME_WR_PINGPONG_EN
        send_frame(pat(40), 0, -1);
        idle(2);
        check_val("pp.drop", 32'(wr_q.size()), 32'd0);
        check_val("pp.ovf", 32'(oOVF), 32'd1);
        iREL = 2'b01;
        idle(1);
        iREL = 2'b00;
        check_val("pp.ovf_sticky", 32'(oOVF), 32'd1);
        send_frame(pat(41), 0, -1);
        expect_wr("pp.after_rel", 0, pat(41), 1'b0, r);
`else
        send_frame(pat(40), 0, -1);
        expect_wr("sb.third", 0, pat(40), 1'b0, r);
        check_val("sb.ovf", 32'(oOVF), 32'd0);
`endif
        idle(5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
